veresk_req_ctrl: RTL
====================

// Module: veresk_req_ctrl
// PURPOSE
//  Transaction controller directly up/downstream of the RS-485 Manchester PHY master (master485n).
//  Frames host request {ADR,CMD,DATA[0..N-1]} into the master's byte-stream handshake, then collects the reply.
//  Reply checks: ADR/CMD echo, payload stored, master parity status, reply timeout.
//  Reports a single completion code to the host.
// PARAMETERS
//  G_BUF_AW    4      address width of TX payload and RX payload buffers (depth 2**G_BUF_AW)
//  G_TMO_CNT   65536  p_in_clk cycles allowed from last TX byte accepted to master status != 0
// PORTS
//  p_in_clk        in   1   system clock (128 MHz, same clock as PHY master); single clock domain
//  p_in_rst        in   1   reset, synchronous, active-high
//  p_in_txbuf_wr   in   1   host write strobe, TX payload buffer
//  p_in_txbuf_adr  in   AW  TX payload write address
//  p_in_txbuf_d    in   8   TX payload write data
//  p_in_req_start  in   1   one-cycle start pulse; ignored while p_out_busy=1
//  p_in_req_adr    in   8   device address, captured at start
//  p_in_req_cmd    in   8   device command, captured at start
//  p_in_req_len    in   AW+1 payload byte count 0..2**AW, captured at start; larger values clamped to 2**AW
//  p_out_busy      out  1   transaction in progress
//  p_out_done      out  1   one-cycle pulse: transaction finished, p_out_err/p_out_rxlen valid
//  p_out_err       out  3   0 OK, 1 PARITY, 2 TIMEOUT, 3 ADR_MISMATCH, 4 CMD_MISMATCH, 5 OVERFLOW
//  p_out_rxlen     out  AW+1 reply payload bytes stored (excludes ADR/CMD)
//  p_in_rxbuf_adr  in   AW  host read address, RX payload buffer
//  p_out_rxbuf_d   out  8   RX payload data, registered, 1-cycle read latency
//  p_out_txd_rdy   out  1   to master p_in_txd_rdy
//  p_out_txd       out  8   to master p_in_txd; held stable until p_in_txd_rd
//  p_in_txd_rd     in   1   from master p_out_txd_rd: one-cycle pulse, current byte consumed
//  p_in_rxd        in   8   from master p_out_rxd
//  p_in_rxd_wr     in   1   from master p_out_rxd_wr: one-cycle pulse, p_in_rxd valid
//  p_in_status     in   3   from master p_out_status: 0 none, 1 RX_OK, 2 RX_ERR
// BEHAVIOUR
//  Reset values
//   - busy, done, txd_rdy = 0; txd = 8'h00; err = 0; rxlen = 0; rxbuf_d = 0.
//   - FSM in S_IDLE; all counters 0. Buffer contents are not reset.
//  Reset mid-transaction: abort at once, txd_rdy drops the next cycle, no done pulse.
//  FSM states
//   - S_IDLE: on start, capture adr/cmd/len, clear err/rxlen and byte index, busy=1, txd=adr, txd_rdy=1 -> S_TX_ADR.
//   - S_TX_ADR: on txd_rd, txd=cmd -> S_TX_CMD.
//   - S_TX_CMD: on txd_rd, if len=0 go to S_ACK_WAIT; else txd=txbuf[0] -> S_TX_DATA.
//   - S_TX_DATA: on txd_rd, idx++; if idx=len-1 -> S_ACK_WAIT; else txd=txbuf[idx+1].
//     TX buffer is read combinationally or prefetched; txd must be valid before the next txd_rd.
//   - Every transition into S_ACK_WAIT: txd_rdy<=0 in the same registered update, i.e. 1 clk after the last txd_rd
//     (master samples rdy >=2 clk4x ticks later).
//   - S_ACK_WAIT: timeout counter runs; each rxd_wr handled as below.
//     status!=0 -> S_DONE. Counter = G_TMO_CNT-1 with status=0 -> err=TIMEOUT (if err=0) -> S_DONE.
//   - S_DONE: done=1 for 1 cycle, busy=0 -> S_IDLE.
//  RX byte handling (byte counter rc)
//   - rc=0: compare with req_adr; mismatch -> ADR_MISMATCH.
//   - rc=1: compare with req_cmd; mismatch -> CMD_MISMATCH.
//   - rc>=2: write rxbuf[rxlen], rxlen++; if rxlen already 2**AW -> OVERFLOW, byte dropped, rxlen saturates.
//  Error rules
//   - err is sticky; first error wins, set only while err=0.
//   - status=2 sets PARITY only if err=0.
//   - status=1 after an earlier error leaves that error intact.
//   - rxd_wr and status!=0 in the same cycle: the byte is processed first, then S_DONE.
//   - rxd_wr outside S_ACK_WAIT is ignored.
//   - Host txbuf writes during busy are allowed, but bytes already loaded are unaffected.
//  Arithmetic
//   - Timeout counter: $clog2(G_TMO_CNT) bits, cleared on S_ACK_WAIT entry.
//   - Byte indices: AW+1 bits, no wrap.
// STRUCTURE
//  - veresk21_def.v (shared `include): error codes VR_ERR_*, master status codes CI_STATUS_RX_OK/ERR, FSM encodings.
//  - Sub-module veresk_buf: 2**AW x 8 simple dual-port register file (sync write, registered read).
//    Instantiated twice (TX payload, RX payload).
// TESTING (bench uses behavioural master model or real master485n loopback with slave model)
//  1 adr=8'h15 cmd=8'h03 len=2 txbuf={A5,5A}; slave replies 15,03,11,22 status=1
//    -> txd sequence 15,03,A5,5A; done err=0 rxlen=2 rxbuf={11,22}.
//  2 len=0, slave replies 15,03 -> exactly 2 txd_rd; txd_rdy low 1 clk after 2nd rd; done err=0 rxlen=0.
//  3 Reply first byte 16 (adr 15), status=1 -> err=3.
//    Second run: reply 15,03,.. then status=2 -> err=3 remains for run 1; run 2 (adr ok) -> err=1.
//  4 No reply, status stays 0 -> done exactly G_TMO_CNT clks after S_ACK_WAIT entry, err=2.
//    Next start still accepted.
//  5 AW=4, slave sends 15,03 + 17 data bytes -> rxlen=16, err=5, rxbuf[15]=16th byte.
//  6 Sync reset asserted during S_TX_DATA -> next clk busy=0, txd_rdy=0, no done.
//    start during busy ignored (no second capture).

Source files
------------

// File: rtl/veresk_req_ctrl_pkg.sv
// Shared definitions for the veresk request controller.
//   - completion/error codes reported to the host
//   - status codes driven by the RS-485 PHY master
//   - FSM state encodings
package veresk_req_ctrl_pkg;

  typedef logic [2:0] err_code_t;

  localparam err_code_t VR_ERR_OK           = 3'd0;
  localparam err_code_t VR_ERR_PARITY       = 3'd1;
  localparam err_code_t VR_ERR_TIMEOUT      = 3'd2;
  localparam err_code_t VR_ERR_ADR_MISMATCH = 3'd3;
  localparam err_code_t VR_ERR_CMD_MISMATCH = 3'd4;
  localparam err_code_t VR_ERR_OVERFLOW     = 3'd5;

  localparam logic [2:0] CI_STATUS_NONE   = 3'd0;
  localparam logic [2:0] CI_STATUS_RX_ERR = 3'd2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TX_ADR   = 3'd1;
  localparam logic [2:0] S_TX_CMD   = 3'd2;
  localparam logic [2:0] S_TX_DATA  = 3'd3;
  localparam logic [2:0] S_ACK_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

endpackage

// File: rtl/veresk_buf.sv
// Simple dual-port byte register file: synchronous write, registered read.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (clears only the read register)
//   wr     write strobe
//   wadr   write address
//   wdata  write data
//   radr   read address
//   rdata  read data, one cycle after radr
module veresk_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [AW-1:0] wadr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] radr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr) mem[wadr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= 8'h00;
    else     rdata <= mem[radr];
  end

endmodule

// File: rtl/veresk_req_ctrl.sv
// Transaction controller sitting on the byte-stream side of the RS-485
// Manchester PHY master. Sends {ADR, CMD, payload} to the master, collects
// the reply, checks the ADR/CMD echo, stores the reply payload and reports
// one completion code per transaction.
// Ports:
//   p_in_clk / p_in_rst           clock, synchronous active-high reset
//   p_in_txbuf_*                  host write port of the TX payload buffer
//   p_in_req_*                    start pulse and request header/length
//   p_out_busy/done/err/rxlen     transaction status to the host
//   p_in_rxbuf_adr/p_out_rxbuf_d  host read port of the RX payload buffer
//   p_out_txd_rdy/p_out_txd       byte offered to the master
//   p_in_txd_rd                   master consumed the offered byte
//   p_in_rxd/p_in_rxd_wr          reply byte from the master
//   p_in_status                   master reply status
//
// state      | meaning
// S_IDLE     | waiting for start
// S_TX_ADR   | device address offered to master
// S_TX_CMD   | command byte offered to master
// S_TX_DATA  | payload bytes offered to master
// S_ACK_WAIT | request sent, collecting reply until status or timeout
// S_DONE     | one-cycle done pulse, a new start is already accepted here
module veresk_req_ctrl
  import veresk_req_ctrl_pkg::*;
#(
  parameter int G_BUF_AW  = 4,
  parameter int G_TMO_CNT = 65536
) (
  input  logic                p_in_clk,
  input  logic                p_in_rst,
  input  logic                p_in_txbuf_wr,
  input  logic [G_BUF_AW-1:0] p_in_txbuf_adr,
  input  logic [7:0]          p_in_txbuf_d,
  input  logic                p_in_req_start,
  input  logic [7:0]          p_in_req_adr,
  input  logic [7:0]          p_in_req_cmd,
  input  logic [G_BUF_AW:0]   p_in_req_len,
  output logic                p_out_busy,
  output logic                p_out_done,
  output logic [2:0]          p_out_err,
  output logic [G_BUF_AW:0]   p_out_rxlen,
  input  logic [G_BUF_AW-1:0] p_in_rxbuf_adr,
  output logic [7:0]          p_out_rxbuf_d,
  output logic                p_out_txd_rdy,
  output logic [7:0]          p_out_txd,
  input  logic                p_in_txd_rd,
  input  logic [7:0]          p_in_rxd,
  input  logic                p_in_rxd_wr,
  input  logic [2:0]          p_in_status
);

  localparam int AW    = G_BUF_AW;
  localparam int TMO_W = (G_TMO_CNT > 1) ? $clog2(G_TMO_CNT) : 1;

  localparam logic [AW:0]      BUF_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(G_TMO_CNT - 1);

  logic [2:0]       state;
  logic [7:0]       req_adr;
  logic [7:0]       req_cmd;
  logic [AW:0]      req_len;
  logic [AW:0]      tx_idx;
  logic [AW-1:0]    tx_ptr;
  logic [AW-1:0]    tx_ptr_nxt;
  logic [7:0]       tx_rdata;
  logic [1:0]       rx_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic      start_ok;
  logic      rx_act;
  logic      rx_store;
  err_code_t rx_code;
  err_code_t err_after_rx;
  err_code_t err_nxt;
  logic      ack_end;
  logic [AW:0] len_clamped;

  assign start_ok    = p_in_req_start && ((state == S_IDLE) || (state == S_DONE));
  assign len_clamped = (p_in_req_len > BUF_DEPTH) ? BUF_DEPTH : p_in_req_len;

  // Reply bytes: rx_cnt saturates at 2, everything from the third byte on is payload.
  assign rx_act   = (state == S_ACK_WAIT) && p_in_rxd_wr;
  assign rx_store = rx_act && (rx_cnt == 2'd2) && (p_out_rxlen != BUF_DEPTH);

  always_comb begin
    rx_code = VR_ERR_OK;
    if (rx_act) begin
      if (rx_cnt == 2'd0) begin
        if (p_in_rxd != req_adr) rx_code = VR_ERR_ADR_MISMATCH;
      end else if (rx_cnt == 2'd1) begin
        if (p_in_rxd != req_cmd) rx_code = VR_ERR_CMD_MISMATCH;
      end else if (p_out_rxlen == BUF_DEPTH) begin
        rx_code = VR_ERR_OVERFLOW;
      end
    end
  end

  // A byte arriving together with a status is judged before the status.
  assign err_after_rx = (p_out_err == VR_ERR_OK) ? rx_code : p_out_err;
  assign ack_end      = (p_in_status != CI_STATUS_NONE) || (tmo_cnt == TMO_LAST);

  always_comb begin
    err_nxt = err_after_rx;
    if (err_after_rx == VR_ERR_OK) begin
      if (p_in_status == CI_STATUS_RX_ERR)
        err_nxt = VR_ERR_PARITY;
      else if ((p_in_status == CI_STATUS_NONE) && (tmo_cnt == TMO_LAST))
        err_nxt = VR_ERR_TIMEOUT;
    end
  end

  // TX buffer read address runs one step ahead of the offered byte, so the
  // registered read data already holds the next payload byte when txd_rd
  // arrives, even for back-to-back reads.
  always_comb begin
    tx_ptr_nxt = tx_ptr;
    if (start_ok)
      tx_ptr_nxt = '0;
    else if ((state == S_TX_CMD) && p_in_txd_rd)
      tx_ptr_nxt = AW'(1);
    else if ((state == S_TX_DATA) && p_in_txd_rd)
      tx_ptr_nxt = tx_ptr + 1'b1;
  end

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) tx_ptr <= '0;
    else          tx_ptr <= tx_ptr_nxt;
  end

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      state         <= S_IDLE;
      req_adr       <= 8'h00;
      req_cmd       <= 8'h00;
      req_len       <= '0;
      tx_idx        <= '0;
      rx_cnt        <= 2'd0;
      tmo_cnt       <= '0;
      p_out_busy    <= 1'b0;
      p_out_done    <= 1'b0;
      p_out_err     <= VR_ERR_OK;
      p_out_rxlen   <= '0;
      p_out_txd_rdy <= 1'b0;
      p_out_txd     <= 8'h00;
    end else begin
      p_out_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start_ok) begin
            req_adr       <= p_in_req_adr;
            req_cmd       <= p_in_req_cmd;
            req_len       <= len_clamped;
            tx_idx        <= '0;
            rx_cnt        <= 2'd0;
            p_out_err     <= VR_ERR_OK;
            p_out_rxlen   <= '0;
            p_out_busy    <= 1'b1;
            p_out_txd     <= p_in_req_adr;
            p_out_txd_rdy <= 1'b1;
            state         <= S_TX_ADR;
          end
        end
        S_TX_ADR: begin
          if (p_in_txd_rd) begin
            p_out_txd <= req_cmd;
            state     <= S_TX_CMD;
          end
        end
        S_TX_CMD: begin
          if (p_in_txd_rd) begin
            if (req_len == '0) begin
              p_out_txd_rdy <= 1'b0;
              tmo_cnt       <= '0;
              state         <= S_ACK_WAIT;
            end else begin
              p_out_txd <= tx_rdata;
              state     <= S_TX_DATA;
            end
          end
        end
        S_TX_DATA: begin
          if (p_in_txd_rd) begin
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == req_len - 1'b1) begin
              p_out_txd_rdy <= 1'b0;
              tmo_cnt       <= '0;
              state         <= S_ACK_WAIT;
            end else begin
              p_out_txd <= tx_rdata;
            end
          end
        end
        S_ACK_WAIT: begin
          tmo_cnt   <= tmo_cnt + 1'b1;
          p_out_err <= err_nxt;
          if (rx_act && (rx_cnt != 2'd2)) rx_cnt <= rx_cnt + 1'b1;
          if (rx_store) p_out_rxlen <= p_out_rxlen + 1'b1;
          if (ack_end) begin
            p_out_done <= 1'b1;
            p_out_busy <= 1'b0;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  veresk_buf #(.AW(AW)) u_txbuf (
    .clk   (p_in_clk),
    .rst   (p_in_rst),
    .wr    (p_in_txbuf_wr),
    .wadr  (p_in_txbuf_adr),
    .wdata (p_in_txbuf_d),
    .radr  (tx_ptr_nxt),
    .rdata (tx_rdata)
  );

  veresk_buf #(.AW(AW)) u_rxbuf (
    .clk   (p_in_clk),
    .rst   (p_in_rst),
    .wr    (rx_store),
    .wadr  (p_out_rxlen[AW-1:0]),
    .wdata (p_in_rxd),
    .radr  (p_in_rxbuf_adr),
    .rdata (p_out_rxbuf_d)
  );

endmodule
